// File: rtl/icache_refill_arbiter.sv
// rtl/icache_refill_arbiter.sv - round-robin refill arbiter sharing one instruction-memory port
//
// Purpose:
//   Arbitrates cacheline refill requests from NumReq instruction caches onto a
//   single memory request port. Memory responses arrive strictly in request
//   order. An outstanding-ID FIFO remembers which cache each one belongs to.
//   Request and response paths are both purely combinational.
//
// Optional feature:
//   ICACHE_REFILL_ARB_PERF_EN - when defined, perf_stall_cycles_o counts the
//   cycles where some cache is requesting but nothing is accepted by memory
//   (saturating). When undefined, the output is tied to 0.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/req_addr_i     per-cache refill request and cacheline address
//   req_ready_o          per-cache grant (one-hot or zero)
//   rsp_valid_o          per-cache response strobe (one-hot or zero)
//   rsp_data_o           response cacheline, broadcast to all caches
//   mem_req_o/mem_addr_o request to shared memory, address of current winner
//   mem_ready_i          memory accepts the request this cycle
//   mem_valid_i/mem_data_i in-order memory response
//   perf_stall_cycles_o  arbitration stall counter
module icache_refill_arbiter #(
  parameter int NumReq         = 4,
  parameter int AddrWidth      = 31,
  parameter int LineWidth      = 64,
  parameter int MaxOutstanding = 4,
  parameter int ReqIdWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic [LineWidth-1:0]        rsp_data_o,
  output logic                        mem_req_o,
  output logic [AddrWidth-1:0]        mem_addr_o,
  input  logic                        mem_ready_i,
  input  logic                        mem_valid_i,
  input  logic [LineWidth-1:0]        mem_data_i,
  output logic [31:0]                 perf_stall_cycles_o
);

  localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  logic [ReqIdWidth-1:0] r_rr;
  logic [ReqIdWidth-1:0] w_winner;
  logic                  w_found;
  logic                  w_any;
  logic                  w_grant;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ReqIdWidth-1:0] w_head;

  logic [ReqIdWidth-1:0] r_fifo [MaxOutstanding];
  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [CntWidth-1:0]   r_count;

  // Wrap explicitly so non-power-of-two-safe and depth-1 FIFOs stay in range.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CntWidth'(MaxOutstanding));
  assign w_empty = (r_count == '0);
  assign w_any   = |req_i;

  // First asserted request scanning upward from the rr pointer, wrapping.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (!w_found && req_i[(int'(r_rr) + k) % NumReq]) begin
        w_found  = 1'b1;
        w_winner = ReqIdWidth'((int'(r_rr) + k) % NumReq);
      end
    end
  end

  // A full FIFO blocks grants even when a pop happens in the same cycle.
  assign w_grant     = w_found && mem_ready_i && !w_full;
  assign req_ready_o = w_grant ? (NumReq'(1) << w_winner) : '0;
  assign mem_req_o   = w_any && !w_full;
  assign mem_addr_o  = w_found ? req_addr_i[w_winner*AddrWidth +: AddrWidth] : '0;

  // A response on an empty FIFO is a protocol error and is not forwarded.
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_pop       = mem_valid_i && !w_empty;
  assign rsp_valid_o = w_pop ? (NumReq'(1) << w_head) : '0;
  assign rsp_data_o  = mem_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (w_grant) begin
      r_rr <= (w_winner == ReqIdWidth'(NumReq - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  // ID storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_fifo[r_wr_ptr] <= w_winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_grant) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ICACHE_REFILL_ARB_PERF_EN
  logic [31:0] r_perf_cnt;
  logic        w_stall;

  assign w_stall = w_any && !(mem_req_o && mem_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_cnt <= '0;
    end else if (w_stall && (r_perf_cnt != '1)) begin
      r_perf_cnt <= r_perf_cnt + 1'b1;
    end
  end

  assign perf_stall_cycles_o = r_perf_cnt;
`else
  assign perf_stall_cycles_o = '0;
`endif

`ifndef SYNTHESIS
  a_no_rsp_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_valid_i && w_empty))
    else $fatal(1, "icache_refill_arbiter: FAIL mem_valid_i with empty outstanding FIFO");
`endif

endmodule
